// File: rtl/nmt_pkg.sv
// Shared widths and storage types for the thread-context bank.
package nmt_pkg;

    localparam int NMT_NUM_FIELDS = 15;
    localparam int NMT_DATA_W     = 32;
    localparam int NMT_ADDR_W     = 32;

    typedef logic [NMT_NUM_FIELDS-1:0][NMT_DATA_W-1:0] nmt_fields_t;

    typedef struct packed {
        logic                  valid;
        logic [NMT_ADDR_W-1:0] tag;
        nmt_fields_t           fields;
    } nmt_entry_t;

endpackage

// File: rtl/nmt_ctx_alloc.sv
// Combinational tag lookup for NUM_Q addresses plus lowest-free-slot pick.
// Slots released this cycle by lookups flagged in rel_en count as free.
module nmt_ctx_alloc
    import nmt_pkg::*;
#(
    parameter int NUM_CTX = 4,
    parameter int ADDR_W  = NMT_ADDR_W,
    parameter int NUM_Q   = 3,
    localparam int IDX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic [NUM_CTX-1:0]             valid,
    input  logic [NUM_CTX-1:0][ADDR_W-1:0] tags,
    input  logic [NUM_Q-1:0][ADDR_W-1:0]   addr,
    input  logic [NUM_Q-1:0]               rel_en,
    output logic [NUM_Q-1:0]               hit,
    output logic [NUM_Q-1:0][IDX_W-1:0]    match_idx,
    output logic [IDX_W-1:0]               free_idx,
    output logic                           free_ok
);

    logic [NUM_Q-1:0][NUM_CTX-1:0] mvec;
    logic [NUM_CTX-1:0]            avail;

    for (genvar q = 0; q < NUM_Q; q++) begin : g_q
        for (genvar i = 0; i < NUM_CTX; i++) begin : g_i
            assign mvec[q][i] = valid[i] && (tags[i] == addr[q]);
        end
    end

    // Tags are unique, so at most one bit per lookup is set.
    always_comb begin
        hit       = '0;
        match_idx = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (mvec[q][i]) begin
                    hit[q]       = 1'b1;
                    match_idx[q] = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        avail = ~valid;
        for (int q = 0; q < NUM_Q; q++) begin
            if (rel_en[q]) avail = avail | mvec[q];
        end
    end

    always_comb begin
        free_ok  = |avail;
        free_idx = '0;
        for (int i = NUM_CTX - 1; i >= 0; i--) begin
            if (avail[i]) free_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/nmt_context_bank.sv
// Save/restore bank of pipeline-register contexts keyed by thread tag.
// Restores read pre-edge contents and consume the entry.
module nmt_context_bank
    import nmt_pkg::*;
#(
    parameter int NUM_CTX    = 4,
    parameter int NUM_FIELDS = NMT_NUM_FIELDS,
    parameter int DATA_W     = NMT_DATA_W,
    parameter int ADDR_W     = NMT_ADDR_W,
    localparam int OCC_W     = $clog2(NUM_CTX + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ctx_switch,
    input  logic [ADDR_W-1:0]                   save_addr,
    input  logic [ADDR_W-1:0]                   restore_addr,
    input  logic [NUM_FIELDS-1:0][DATA_W-1:0]   live_in,
    input  logic                                free_valid,
    input  logic [ADDR_W-1:0]                   free_addr,
    output logic [NUM_FIELDS-1:0][DATA_W-1:0]   ctx_out,
    output logic                                restore_valid,
    output logic                                restore_miss,
    output logic                                overflow,
    output logic [OCC_W-1:0]                    occupancy,
    output logic                                full
);

    localparam int IDX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

    nmt_entry_t                     tbl [NUM_CTX];
    logic [NUM_CTX-1:0]             valid_vec, valid_nxt;
    logic [NUM_CTX-1:0][ADDR_W-1:0] tag_vec;
    logic [2:0][ADDR_W-1:0]         lk_addr;
    logic [2:0]                     lk_rel, hit;
    logic [2:0][IDX_W-1:0]          match_idx;
    logic [IDX_W-1:0]               free_idx, wr_idx;
    logic                           free_ok, save_blk, wr_en, ovf_nxt;
    logic [OCC_W-1:0]               occ_nxt;

    always_comb begin
        for (int i = 0; i < NUM_CTX; i++) begin
            valid_vec[i] = tbl[i].valid;
            tag_vec[i]   = tbl[i].tag;
        end
    end

    // Lookup 0 = save, 1 = restore, 2 = free; restore and free release slots.
    assign lk_addr = {free_addr, restore_addr, save_addr};
    assign lk_rel  = {free_valid, ctx_switch, 1'b0};

    nmt_ctx_alloc #(
        .NUM_CTX (NUM_CTX),
        .ADDR_W  (ADDR_W),
        .NUM_Q   (3)
    ) u_alloc (
        .valid     (valid_vec),
        .tags      (tag_vec),
        .addr      (lk_addr),
        .rel_en    (lk_rel),
        .hit       (hit),
        .match_idx (match_idx),
        .free_idx  (free_idx),
        .free_ok   (free_ok)
    );

    // Clears go first so a save may land in a slot released this cycle;
    // a free of the saved tag suppresses the save entirely.
    always_comb begin
        save_blk  = free_valid && (free_addr == save_addr);
        valid_nxt = valid_vec;
        wr_en     = 1'b0;
        wr_idx    = match_idx[0];
        ovf_nxt   = 1'b0;
        if (ctx_switch && hit[1]) valid_nxt[match_idx[1]] = 1'b0;
        if (free_valid && hit[2]) valid_nxt[match_idx[2]] = 1'b0;
        if (ctx_switch && !save_blk) begin
            if (hit[0]) begin
                wr_en = 1'b1;
            end else if (free_ok) begin
                wr_en  = 1'b1;
                wr_idx = free_idx;
            end else begin
                ovf_nxt = 1'b1;
            end
        end
        if (wr_en) valid_nxt[wr_idx] = 1'b1;
        occ_nxt = '0;
        for (int i = 0; i < NUM_CTX; i++) occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTX; i++) tbl[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CTX; i++) begin
                tbl[i].valid <= valid_nxt[i];
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    tbl[i].tag    <= save_addr;
                    tbl[i].fields <= live_in;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx_out       <= '0;
            restore_valid <= 1'b0;
            restore_miss  <= 1'b0;
            overflow      <= 1'b0;
            occupancy     <= '0;
        end else begin
            restore_valid <= ctx_switch && hit[1];
            restore_miss  <= ctx_switch && !hit[1];
            overflow      <= ovf_nxt;
            occupancy     <= occ_nxt;
            if (ctx_switch && hit[1]) ctx_out <= tbl[match_idx[1]].fields;
        end
    end

    assign full = (occupancy == OCC_W'(NUM_CTX));

endmodule

// File: tb/tb_nmt_context_bank.sv
// Directed plus random bench for nmt_context_bank against a tag-keyed map model.
module tb_nmt_context_bank;

    localparam int NC = 4;
    localparam int NF = 15;
    localparam int DW = 32;
    localparam int AW = 32;

    typedef logic [NF-1:0][DW-1:0] fl_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctx_switch;
    logic [AW-1:0] save_addr, restore_addr, free_addr;
    fl_t           live_in;
    logic          free_valid;
    fl_t           ctx_out;
    logic          restore_valid, restore_miss, overflow, full;
    logic [2:0]    occupancy;

    always #5 clk = ~clk;

    nmt_context_bank #(
        .NUM_CTX    (NC),
        .NUM_FIELDS (NF),
        .DATA_W     (DW),
        .ADDR_W     (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ctx_switch    (ctx_switch),
        .save_addr     (save_addr),
        .restore_addr  (restore_addr),
        .live_in       (live_in),
        .free_valid    (free_valid),
        .free_addr     (free_addr),
        .ctx_out       (ctx_out),
        .restore_valid (restore_valid),
        .restore_miss  (restore_miss),
        .overflow      (overflow),
        .occupancy     (occupancy),
        .full          (full)
    );

    int   checks = 0;
    int   errors = 0;
    fl_t  model [logic [AW-1:0]];
    fl_t  exp_out;
    logic exp_rv, exp_rm, exp_ov;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".restore_valid"}, 512'(restore_valid), 512'(exp_rv));
        chk({tag, ".restore_miss"},  512'(restore_miss),  512'(exp_rm));
        chk({tag, ".overflow"},      512'(overflow),      512'(exp_ov));
        chk({tag, ".occupancy"},     512'(occupancy),     512'(model.size()));
        chk({tag, ".full"},          512'(full),          512'(model.size() == NC));
        chk({tag, ".ctx_out"},       512'(ctx_out),       512'(exp_out));
    endtask

    // Model: a map tag->fields with capacity NC; a restore consumes its tag,
    // a free removes its tag, then the save writes if it fits.
    task automatic step(input string tag, input logic sw, input logic [AW-1:0] sa,
                        input logic [AW-1:0] ra, input fl_t live,
                        input logic fv, input logic [AW-1:0] fa);
        bit rh, sh;
        @(negedge clk);
        ctx_switch = sw; save_addr = sa; restore_addr = ra;
        live_in = live;  free_valid = fv; free_addr = fa;
        rh = sw && model.exists(ra);
        sh = model.exists(sa);
        exp_rv = rh;
        exp_rm = sw && !rh;
        exp_ov = 1'b0;
        if (rh) begin
            exp_out = model[ra];
            model.delete(ra);
        end
        if (fv) model.delete(fa);
        if (sw && !(fv && fa == sa)) begin
            if (sh || model.size() < NC) model[sa] = live;
            else exp_ov = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    function automatic fl_t f0(input logic [DW-1:0] v);
        fl_t f;
        f = '0;
        f[0] = v;
        return f;
    endfunction

    function automatic fl_t rnd_fields();
        fl_t f;
        for (int i = 0; i < NF; i++) f[i] = $urandom;
        return f;
    endfunction

    initial begin
        rst = 1'b1; ctx_switch = 1'b0; save_addr = '0; restore_addr = '0;
        live_in = '0; free_valid = 1'b0; free_addr = '0;
        exp_out = '0; exp_rv = 1'b0; exp_rm = 1'b0; exp_ov = 1'b0;
        @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // save then restore; a same-cycle free of the save tag blocks the save
        step("save10",    1'b1, 32'h10, 32'h99, f0(32'hAAAA), 1'b0, 32'h0);
        step("restore10", 1'b1, 32'h55, 32'h10, f0(32'h0),    1'b1, 32'h55);
        step("idle0",     1'b0, 32'h0,  32'h0,  f0(32'h0),    1'b0, 32'h0);

        // fill and overflow
        for (int t = 1; t <= NC; t++)
            step("fill", 1'b1, AW'(t), 32'hDEAD, f0(DW'(t)), 1'b0, 32'h0);
        step("ovf",   1'b1, 32'h5, 32'hDEAD, f0(32'h5), 1'b0, 32'h0);
        step("idle1", 1'b0, 32'h0, 32'h0,    f0(32'h0), 1'b0, 32'h0);

        // free plus save into the released slot while full
        step("freesave",  1'b1, 32'h9,  32'hDEAD, f0(32'h9999), 1'b1, 32'h2);
        step("restore9",  1'b1, 32'h20, 32'h9,    f0(32'h1111), 1'b0, 32'h0);

        // same-tag swap
        step("swap1", 1'b1, 32'h20, 32'h20, f0(32'h2222), 1'b0, 32'h0);
        step("swap2", 1'b1, 32'h20, 32'h20, f0(32'h3333), 1'b0, 32'h0);

        // restore miss keeps ctx_out
        step("miss",  1'b1, 32'h20, 32'h77, f0(32'h4444), 1'b0, 32'h0);

        // free and restore of the same tag
        step("freerst", 1'b1, 32'h20, 32'h1, f0(32'h5555), 1'b1, 32'h1);
        step("freenop", 1'b0, 32'h0,  32'h0, f0(32'h0),    1'b1, 32'h88);

        // async reset in the middle of a ctx_switch
        @(negedge clk);
        ctx_switch = 1'b1; save_addr = 32'h30; restore_addr = 32'h3;
        live_in = f0(32'h6666); free_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model.delete();
        exp_out = '0; exp_rv = 1'b0; exp_rm = 1'b0; exp_ov = 1'b0;
        chk_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        ctx_switch = 1'b0;
        step("post_rst", 1'b0, 32'h0, 32'h3, f0(32'h0), 1'b0, 32'h0);

        // random traffic over a small tag space to hit full and collisions
        for (int n = 0; n < 400; n++) begin
            step("rand", ($urandom_range(0, 9) < 7),
                 AW'($urandom_range(1, 6)), AW'($urandom_range(1, 6)),
                 rnd_fields(), ($urandom_range(0, 9) < 3), AW'($urandom_range(1, 6)));
        end
        step("final", 1'b0, 32'h0, 32'h0, f0(32'h0), 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nmt_context_bank.md
NMT_CONTEXT_BANK -- requirements
Module: nmt_context_bank

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  NUM_CTX, 4, number of stored thread contexts.
  NUM_FIELDS, 15, number of pipeline-register fields per context.
  DATA_W, 32, width of each field.
  ADDR_W, 32, width of the thread-address tag.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock, rising edge.
  rst  in  1  reset, asynchronous, active-high.
  ctx_switch  in  1  context-switch strobe, one cycle.
  save_addr  in  ADDR_W  tag of the outgoing thread.
  restore_addr  in  ADDR_W  tag of the incoming thread.
  live_in  in  NUM_FIELDS x DATA_W  current stage register values.
  free_valid  in  1  thread-release strobe.
  free_addr  in  ADDR_W  tag of the released thread.
  ctx_out  out  NUM_FIELDS x DATA_W  restored field values.
  restore_valid  out  1  mux select, where 1 means use ctx_out.
  restore_miss  out  1  restore tag not present.
  overflow  out  1  save dropped because the table is full.
  occupancy  out  $clog2(NUM_CTX+1)  number of valid entries.
  full  out  1  occupancy equals NUM_CTX.

Function
REQ-003 The table SHALL hold NUM_CTX entries, each consisting of {valid, tag[ADDR_W], fields[NUM_FIELDS][DATA_W]}.
REQ-004 When ctx_switch=1 and an entry is valid with tag==save_addr, live_in SHALL overwrite that entry's fields at the clock edge.
REQ-005 When ctx_switch=1 with no tag match and a free entry exists, the lowest-index invalid entry SHALL be allocated with tag=save_addr and fields=live_in.
REQ-006 When ctx_switch=1 with no tag match and full=1, the save SHALL be dropped, the table SHALL be unchanged, and overflow SHALL be 1 for exactly the next cycle.
REQ-007 On ctx_switch=1, the entry matching restore_addr SHALL be read using pre-edge contents, i.e. read-before-write.
REQ-008 On a restore hit, ctx_out SHALL present the stored fields and restore_valid SHALL be 1 for exactly one cycle, with one cycle of latency after ctx_switch.
REQ-009 On a restore hit, the matching entry SHALL be invalidated, because the context is consumed.
REQ-010 On a restore miss, restore_miss SHALL be 1 and restore_valid SHALL be 0 for one cycle, and ctx_out SHALL hold its previous value.
REQ-011 When restore_addr==save_addr on a hit, the entry SHALL return its old fields and SHALL then hold live_in, remaining valid.
REQ-012 When free_valid=1, any valid entry with tag==free_addr SHALL be invalidated; a free with no matching tag SHALL have no effect.
REQ-013 When free and save target the same tag in one cycle, the free SHALL win, leaving the entry invalid with no allocation.
REQ-014 When free and restore target the same tag in one cycle, the restore SHALL still return the data and the entry SHALL end invalid.
REQ-015 A freed slot SHALL become available for allocation in the same cycle: with full=1, a save plus a free of a different tag SHALL allocate into the freed slot, and overflow SHALL be 0.
REQ-016 occupancy SHALL be registered and SHALL equal the post-edge count of valid entries.
REQ-017 full SHALL be combinational from occupancy.
REQ-018 Tags SHALL be unique; at most one valid entry SHALL match any address.
REQ-019 When ctx_switch=0, restore_valid, restore_miss and overflow SHALL all be 0.

Reset
REQ-020 Asserting rst SHALL immediately clear all valid bits and SHALL set occupancy, restore_valid, restore_miss and overflow to 0 and ctx_out to 0.
REQ-021 Entry fields and tags need not be reset.
REQ-022 A reset during a ctx_switch cycle SHALL discard both the save and the restore.

Structure
REQ-023 NUM_FIELDS, DATA_W and ADDR_W defaults, the field-array typedef and the entry struct typedef SHALL reside in the shared package nmt_pkg.
REQ-024 Tag match and lowest-free-index priority encoding SHALL be implemented in sub-module nmt_ctx_alloc, which is combinational and outputs a match index, a hit flag, a free index and a free-available flag.
REQ-025 The implementation SHALL be 120-400 lines of RTL and SHALL contain no latches.

Verification
REQ-026 Save then restore: save 0x10 with field0=0xAAAA; later restore 0x10 -> next cycle restore_valid=1, ctx_out[0]=0xAAAA, and occupancy goes 1->0.
REQ-027 Fill and overflow (NUM_CTX=4): save tags 1..4 -> full=1; save tag 5 -> overflow=1 for one cycle and occupancy stays 4.
REQ-028 Simultaneous free and save with full=1: free tag 2 while saving tag 9 -> tag 9 occupies index 1, overflow=0, occupancy=4.
REQ-029 Same-tag swap: 0x20 holds 0x1111; ctx_switch with save=restore=0x20 and live_in[0]=0x2222 -> ctx_out[0]=0x1111, and a later restore of 0x20 returns 0x2222.
REQ-030 Restore miss: restore 0x77, which is absent -> restore_miss=1, restore_valid=0, ctx_out unchanged.
REQ-031 Async reset: assert rst mid-ctx_switch between edges -> all outputs 0 immediately and occupancy=0 after rst deasserts.
